// File: rtl/alu_apb_master.sv
// APB requester for the ALU slave: command FIFO -> one APB transfer per command -> one response.
// Optional watchdog on ACCESS enabled by defining ALU_APB_TIMEOUT_EN.
module alu_apb_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              alu_state,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("alu_apb_master: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nxt;

    logic [FIFO_DEPTH-1:0]             fifo_write;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] fifo_addr;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_wdata;
    logic [PTR_W:0]                    wr_ptr, rd_ptr;
    logic [PTR_W-1:0]                  rd_idx;
    logic fifo_empty, fifo_full, push, done, timeout_hit, pop, start;

    assign rd_idx     = rd_ptr[PTR_W-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign done       = (state == ACCESS) && pready;
    assign pop        = done || timeout_hit;
    assign start      = (state == IDLE) && (state_nxt == SETUP);
    assign busy       = !fifo_empty || (state != IDLE) || rsp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr[PTR_W-1:0]] <= cmd_write;
            fifo_addr[wr_ptr[PTR_W-1:0]]  <= cmd_addr;
            fifo_wdata[wr_ptr[PTR_W-1:0]] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        case (state)
            IDLE:    if (!fifo_empty && !rsp_valid) state_nxt = SETUP;
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign alu_state = psel;

    // Address phase is latched once on SETUP entry and held until the next transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (start) begin
            pwrite <= fifo_write[rd_idx];
            paddr  <= fifo_addr[rd_idx];
            pwdata <= fifo_wdata[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (pop) begin
            rsp_valid <= 1'b1;
            rsp_write <= pwrite;
            rsp_err   <= !done || pslverr;
            rsp_data  <= (done && !pwrite && !pslverr) ? prdata : '0;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                tmo_cnt <= '0;
        else if (state == SETUP)  tmo_cnt <= '0;
        else if (state == ACCESS) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // A late pready on the expiry edge still completes normally.
    assign timeout_hit = (state == ACCESS) && !pready &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    rsp_timeout <= 1'b0;
        else if (pop) rsp_timeout <= timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_apb_master.sv
// Directed + randomized bench for alu_apb_master with a behavioural APB slave and a
// command-queue reference model.
module tb_alu_apb_master;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_data;
    logic          busy, alu_state, psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    alu_apb_master #(
        .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .busy(busy), .alu_state(alu_state),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        cmd_t c;
        int   setup;
        int   acc;
    } slv_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] rd_tab [0:31];
    cmd_t        exp_q [$];
    slv_t        slv_log [$];

    bit slv_stuck = 1'b0;
    bit slv_rand  = 1'b0;
    int slv_wait  = 0;
    int s_setup, s_acc, s_w;
    bit s_was_acc;

    // Slave: updates its outputs 1 time unit after each edge; the main thread samples at +2.
    initial begin
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        s_setup = 0; s_acc = 0; s_w = 0; s_was_acc = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                pready = 1'b0; s_setup = 0; s_acc = 0; s_was_acc = 1'b0;
            end else begin
                if (s_was_acc && pready)
                    slv_log.push_back('{'{pwrite, paddr, pwdata}, s_setup, s_acc});
                if (!psel) begin
                    s_setup = 0; s_acc = 0;
                end else if (!penable) begin
                    s_setup++; s_acc = 0;
                    s_w = slv_rand ? int'($urandom_range(0, 3)) : slv_wait;
                end else begin
                    s_acc++;
                end
                pready = psel && penable && !slv_stuck && (s_acc > s_w);
                // Garbage on prdata/pslverr while not ready must be ignored by the master.
                prdata  = pready ? rd_tab[paddr[4:0]] : $urandom;
                pslverr = pready ? (paddr > 16) : 1'($urandom_range(0, 1));
                s_was_acc = psel && penable;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input bit w, input logic [31:0] a, input logic [31:0] d);
        int t;
        bit ok;
        t = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && t < 200) begin tick(); t++; end
        ok = cmd_ready;
        chk("cmd_accept", ok, 1'b1);
        tick();
        cmd_valid = 1'b0;
        if (ok) exp_q.push_back('{w, a, d});
    endtask

    task automatic get_rsp(input bit tmo, input int exp_acc, input int extra_wait);
        int          t;
        cmd_t        c;
        slv_t        s;
        logic [31:0] ed;
        logic        ee;
        logic [34:0] snap;
        t = 0;
        while (!rsp_valid && t < 300) begin tick(); t++; end
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("exp_q_nonempty", exp_q.size() != 0, 1'b1);
        c  = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        ee = tmo || (c.addr > 16);
        ed = (c.write || ee) ? 32'h0 : rd_tab[c.addr[4:0]];
        chk("rsp_write", rsp_write, c.write);
        chk("rsp_err", rsp_err, ee);
        chk("rsp_timeout", rsp_timeout, tmo);
        chk("rsp_data", rsp_data, ed);
        if (!tmo) begin
            chk("slv_log_nonempty", slv_log.size() != 0, 1'b1);
            s = (slv_log.size() != 0) ? slv_log.pop_front() : '0;
            chk("apb_addr", s.c.addr, c.addr);
            chk("apb_write", s.c.write, c.write);
            if (c.write) chk("apb_wdata", s.c.wdata, c.wdata);
            chk("setup_cycles", s.setup, 1);
            if (exp_acc > 0) chk("access_cycles", s.acc, exp_acc);
        end
        snap = {rsp_write, rsp_err, rsp_timeout, rsp_data};
        repeat (1 + extra_wait) tick();
        chk("rsp_hold", {rsp_valid, rsp_write, rsp_err, rsp_timeout, rsp_data}, {1'b1, snap});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_clear", rsp_valid, 1'b0);
    endtask

    initial begin
        int t;
        int cyc;
        for (int i = 0; i < 32; i++) rd_tab[i] = $urandom;
        rd_tab[5]  = 32'h0000_0123;
        rd_tab[17] = 32'hDEAD_BEEF;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp", {rsp_valid, rsp_write, rsp_err, rsp_timeout, rsp_data}, '0);
        chk("rst_ctl", {busy, alu_state, psel, penable, pwrite}, '0);
        chk("rst_paddr", paddr, '0);
        chk("rst_pwdata", pwdata, '0);
        reset = 1'b0;
        tick();

        // Zero-wait latency: rsp_valid 3 edges after the push edge
        slv_wait = 0;
        push_cmd(1'b0, 32'd9, 32'h0);
        tick();
        chk("lat_setup", {psel, penable, alu_state, busy, rsp_valid}, 5'b10110);
        tick();
        chk("lat_access", {psel, penable, rsp_valid}, 3'b110);
        tick();
        chk("lat_done", {psel, rsp_valid}, 2'b01);
        get_rsp(1'b0, 1, 0);

        // Write with one wait state
        slv_wait = 1;
        push_cmd(1'b1, 32'd0, 32'h1000_4A85);
        get_rsp(1'b0, 2, 0);
        chk("pwdata_held", pwdata, 32'h1000_4A85);

        // Reads: normal and slave error
        slv_wait = 0;
        push_cmd(1'b0, 32'd5, 32'h0);
        get_rsp(1'b0, 1, 0);
        push_cmd(1'b0, 32'd17, 32'h0);
        get_rsp(1'b0, 1, 0);

        // Back-pressure: full FIFO, pending response blocks the next transfer
        slv_stuck = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 20)), $urandom);
        chk("full_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd3; cmd_wdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin tick(); chk("blocked_push", cmd_ready, 1'b0); end
        cmd_valid = 1'b0;
        slv_stuck = 1'b0;
        t = 0;
        while (!rsp_valid && t < 50) begin tick(); t++; end
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        chk("ready_after_pop", cmd_ready, 1'b1);
        push_cmd(1'b0, 32'd5, 32'h0);
        chk("full_again", cmd_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin tick(); chk("stall_no_psel", psel, 1'b0); end
        get_rsp(1'b0, -1, 0);
        tick();
        chk("next_setup", {psel, penable}, 2'b10);
        for (int i = 0; i < 4; i++) get_rsp(1'b0, -1, 0);

        // Randomized traffic against the queue model
        slv_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            push_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 20)), $urandom);
            while (exp_q.size() > int'($urandom_range(0, 3)))
                get_rsp(1'b0, -1, int'($urandom_range(0, 2)));
        end
        while (exp_q.size() != 0) get_rsp(1'b0, -1, 0);
        chk("idle_after_random", busy, 1'b0);
        slv_rand = 1'b0;

        // Stuck slave
        slv_stuck = 1'b1;
        push_cmd(1'b1, 32'd3, 32'h0000_00A5);
        t = 0;
        while (!(psel && penable) && t < 20) begin tick(); t++; end
`ifdef ALU_APB_TIMEOUT_EN
        cyc = 0;
        while (psel && penable && cyc < 40) begin cyc++; tick(); end
        chk("tmo_access_cycles", cyc, TMO);
        slv_stuck = 1'b0;
        get_rsp(1'b1, -1, 0);
`else
        repeat (100) tick();
        chk("no_tmo_psel", {psel, penable}, 2'b11);
        cyc = 0;
        slv_stuck = 1'b0;
        get_rsp(1'b0, -1, cyc);
`endif

        // Async reset mid-ACCESS with two entries queued
        slv_stuck = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(1'b0, 32'(i + 1), 32'h0);
        chk("pre_rst_access", {psel, penable}, 2'b11);
        #3 reset = 1'b1;
        #1 chk("async_rst_apb", {psel, penable, alu_state}, 3'b000);
        tick(); tick();
        reset = 1'b0;
        slv_stuck = 1'b0;
        exp_q.delete();
        slv_log.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst", {rsp_valid, cmd_ready, busy, psel}, 4'b0100);
        end

        // Recovery after reset
        push_cmd(1'b0, 32'd16, 32'h0);
        get_rsp(1'b0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
